// File: rtl/fetch_if.sv
// Fetch/issue bus between the sequencer, its program ROM and the execute unit.
interface fetch_if;
  logic [7:0]  rom_addr;
  logic [11:0] rom_data;
  logic        issue_valid;
  logic        issue_ready;
  logic [3:0]  opcode;
  logic [7:0]  operand;
  logic        br_taken;
  logic [7:0]  br_target;
  logic        halted;
  logic [7:0]  pc_out;

  modport master (
    output rom_addr, issue_valid, opcode, operand, halted, pc_out,
    input  rom_data, issue_ready, br_taken, br_target
  );

  modport slave (
    input  rom_addr, issue_valid, opcode, operand, halted, pc_out,
    output rom_data, issue_ready, br_taken, br_target
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction fetch/issue controller: PC, IR, branch redirect and halt.
// Optional SEQ_SINGLE_STEP_EN adds a step input and a PAUSE state after each issue.
module fetch_sequencer #(
  parameter logic [7:0] RESET_PC = 8'h01,
  parameter logic [3:0] HALT_OP  = 4'h9
) (
  input  logic   clk,
  input  logic   rst,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic   step,
`endif
  fetch_if.master fif
);

  typedef enum logic [1:0] {S_FETCH, S_ISSUE, S_HALT, S_PAUSE} state_t;

  state_t      state_q, state_d;
  logic [7:0]  pc_q, pc_d;
  logic [11:0] ir_q, ir_d;
  logic [7:0]  irpc_q, irpc_d;
  logic [7:0]  pc_inc;

  // Address 0 holds no instruction, so sequential fetch wraps past it.
  assign pc_inc = (pc_q == 8'hFF) ? RESET_PC : pc_q + 8'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      irpc_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      irpc_q  <= irpc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    irpc_d  = irpc_q;
    case (state_q)
      S_FETCH: begin
        ir_d    = fif.rom_data;
        irpc_d  = pc_q;
        state_d = (fif.rom_data[11:8] == HALT_OP) ? S_HALT : S_ISSUE;
      end
      S_ISSUE: begin
        if (fif.issue_ready) begin
          pc_d = fif.br_taken ? fif.br_target : pc_inc;
`ifdef SEQ_SINGLE_STEP_EN
          state_d = S_PAUSE;
`else
          state_d = S_FETCH;
`endif
        end
      end
      S_HALT: state_d = S_HALT;
`ifdef SEQ_SINGLE_STEP_EN
      S_PAUSE: if (step) state_d = S_FETCH;
`endif
      default: state_d = S_FETCH;
    endcase
  end

  assign fif.rom_addr    = pc_q;
  assign fif.issue_valid = (state_q == S_ISSUE);
  assign fif.halted      = (state_q == S_HALT);
  assign fif.opcode      = ir_q[11:8];
  assign fif.operand     = ir_q[7:0];
  assign fif.pc_out      = irpc_q;

endmodule
